// File: rtl/rv32im_csr_access_ctrl_if.sv
// rtl/rv32im_csr_access_ctrl_if.sv - CSR request/response handshake bundle between a requester and the CSR access controller
interface rv32im_csr_access_ctrl_if #(
  parameter int CSR_AW = 12,
  parameter int XLEN   = 32
);
  // request channel
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [CSR_AW-1:0] req_addr;
  logic [XLEN-1:0]   req_operand;
  logic              req_src_zero;
  logic              req_rd_zero;
  // response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_illegal;

  // requester side (execute stage or debug module)
  modport master (
    output req_valid, req_funct3, req_addr, req_operand, req_src_zero, req_rd_zero, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_illegal
  );

  // controller side
  modport slave (
    input  req_valid, req_funct3, req_addr, req_operand, req_src_zero, req_rd_zero, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_illegal
  );
endinterface

// File: rtl/rv32im_csr_access_ctrl.sv
// rtl/rv32im_csr_access_ctrl.sv - Zicsr read-modify-write sequencer in front of the CSR regfile (optional CSR_DBG_PORT_EN adds a debug requester)
module rv32im_csr_access_ctrl #(
  parameter int CSR_AW = 12,
  parameter int XLEN   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rv32im_csr_access_ctrl_if.slave core,
`ifdef CSR_DBG_PORT_EN
  rv32im_csr_access_ctrl_if.slave dbg,
`endif
  output logic [CSR_AW-1:0]   csr_addr_o,
  output logic [XLEN-1:0]     csr_wdata_o,
  output logic                csr_read_en_o,
  output logic                csr_write_en_o,
  input  logic [XLEN-1:0]     csr_rdata_i,
  input  logic [1:0]          priv_mode_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // latched request
  logic [CSR_AW-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   operand_q;
  logic              src_zero_q;
  logic              rd_zero_q;
  logic              is_dbg_q;
  logic [XLEN-1:0]   old_q;
  logic              illegal_q;

  // handshake qualifiers
  logic core_accept;
  logic dbg_accept;
  logic accept;
  logic resp_ready_sel;

`ifdef CSR_DBG_PORT_EN
  // debug wins a same-cycle tie; the core simply sees ready low
  assign dbg_accept     = (state_q == IDLE) && dbg.req_valid;
  assign core_accept    = (state_q == IDLE) && core.req_valid && !dbg.req_valid;
  assign resp_ready_sel = is_dbg_q ? dbg.resp_ready : core.resp_ready;
`else
  assign dbg_accept     = 1'b0;
  assign core_accept    = (state_q == IDLE) && core.req_valid;
  assign resp_ready_sel = core.resp_ready;
`endif
  assign accept = core_accept | dbg_accept;

  // decode of the latched request
  logic            is_rw;
  logic            write_intent;
  logic            read_needed;
  logic [1:0]      priv_eff;
  logic            illegal_chk;
  logic [XLEN-1:0] op_val;

  assign is_rw        = (funct3_q[1:0] == 2'b01);
  // RW always writes; set/clear only when the source is non-zero
  assign write_intent = is_rw | ~src_zero_q;
  // RW with rd=x0 has no architectural read side effect
  assign read_needed  = ~(is_rw & rd_zero_q);
  assign priv_eff     = is_dbg_q ? 2'b11 : priv_mode_i;
  assign illegal_chk  = (funct3_q[1:0] == 2'b00)
                     || (addr_q[9:8] > priv_eff)
                     || (write_intent && (addr_q[11:10] == 2'b11));
  // I-variants carry a 5-bit zero-extended immediate
  assign op_val       = funct3_q[2] ? {{(XLEN-5){1'b0}}, operand_q[4:0]} : operand_q;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CHECK;
      CHECK: begin
        if (illegal_chk)      state_d = RESP;
        else if (read_needed) state_d = READ;
        else                  state_d = WRITE;
      end
      READ:    state_d = write_intent ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // request latch, legality flag and old-value capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      operand_q  <= '0;
      src_zero_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      is_dbg_q   <= 1'b0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (core_accept) begin
        addr_q     <= core.req_addr;
        funct3_q   <= core.req_funct3;
        operand_q  <= core.req_operand;
        src_zero_q <= core.req_src_zero;
        rd_zero_q  <= core.req_rd_zero;
        is_dbg_q   <= 1'b0;
        old_q      <= '0;
        illegal_q  <= 1'b0;
      end
`ifdef CSR_DBG_PORT_EN
      if (dbg_accept) begin
        addr_q     <= dbg.req_addr;
        funct3_q   <= dbg.req_funct3;
        operand_q  <= dbg.req_operand;
        src_zero_q <= dbg.req_src_zero;
        rd_zero_q  <= dbg.req_rd_zero;
        is_dbg_q   <= 1'b1;
        old_q      <= '0;
        illegal_q  <= 1'b0;
      end
`endif
      if (state_q == CHECK) illegal_q <= illegal_chk;
      if (state_q == READ)  old_q     <= csr_rdata_i;
    end
  end

  // output decode; everything is quiet outside its own phase
  always_comb begin
    core.req_ready    = 1'b0;
    core.resp_valid   = 1'b0;
    core.resp_rdata   = '0;
    core.resp_illegal = 1'b0;
`ifdef CSR_DBG_PORT_EN
    dbg.req_ready     = 1'b0;
    dbg.resp_valid    = 1'b0;
    dbg.resp_rdata    = '0;
    dbg.resp_illegal  = 1'b0;
`endif
    csr_addr_o        = '0;
    csr_wdata_o       = '0;
    csr_read_en_o     = 1'b0;
    csr_write_en_o    = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef CSR_DBG_PORT_EN
        dbg.req_ready  = 1'b1;
        core.req_ready = ~dbg.req_valid;
`else
        core.req_ready = 1'b1;
`endif
      end
      READ: begin
        csr_read_en_o = 1'b1;
        csr_addr_o    = addr_q;
      end
      WRITE: begin
        csr_write_en_o = 1'b1;
        csr_addr_o     = addr_q;
        case (funct3_q[1:0])
          2'b10:   csr_wdata_o = old_q | op_val;
          2'b11:   csr_wdata_o = old_q & ~op_val;
          default: csr_wdata_o = op_val;
        endcase
      end
      RESP: begin
`ifdef CSR_DBG_PORT_EN
        if (is_dbg_q) begin
          dbg.resp_valid   = 1'b1;
          dbg.resp_rdata   = old_q;
          dbg.resp_illegal = illegal_q;
        end else begin
          core.resp_valid   = 1'b1;
          core.resp_rdata   = old_q;
          core.resp_illegal = illegal_q;
        end
`else
        core.resp_valid   = 1'b1;
        core.resp_rdata   = old_q;
        core.resp_illegal = illegal_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32im_csr_access_ctrl.sv
// tb/tb_rv32im_csr_access_ctrl.sv - directed self-checking bench for rv32im_csr_access_ctrl
module tb_rv32im_csr_access_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32im_csr_access_ctrl_if #(.CSR_AW(12), .XLEN(32)) core_bus ();
`ifdef CSR_DBG_PORT_EN
  rv32im_csr_access_ctrl_if #(.CSR_AW(12), .XLEN(32)) dbg_bus ();
`endif

  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_read_en;
  logic        csr_write_en;
  logic [1:0]  priv;

  rv32im_csr_access_ctrl #(.CSR_AW(12), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .core           (core_bus),
`ifdef CSR_DBG_PORT_EN
    .dbg            (dbg_bus),
`endif
    .csr_addr_o     (csr_addr),
    .csr_wdata_o    (csr_wdata),
    .csr_read_en_o  (csr_read_en),
    .csr_write_en_o (csr_write_en),
    .csr_rdata_i    (csr_rdata),
    .priv_mode_i    (priv)
  );

  // regfile model: combinational read, write on the edge
  logic [31:0] mem [0:4095];
  assign csr_rdata = csr_read_en ? mem[csr_addr] : 32'h0;
  always @(posedge clk) if (csr_write_en) mem[csr_addr] <= csr_wdata;

  // strobe monitor
  int          n_rd, n_wr, n_both;
  logic [31:0] last_wdata;
  always @(negedge clk) begin
    if (csr_read_en) n_rd++;
    if (csr_write_en) begin n_wr++; last_wdata = csr_wdata; end
    if (csr_read_en && csr_write_en) n_both++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic run_vec(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] op, input logic sz, input logic rz, input int hold,
                         input logic [31:0] exp_rdata, input logic exp_ill, input int exp_lat,
                         input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata);
    logic [31:0] rdata;
    logic        ill;
    int          lat;
    @(negedge clk);
    core_bus.req_valid    = 1'b1;
    core_bus.req_funct3   = f3;
    core_bus.req_addr     = addr;
    core_bus.req_operand  = op;
    core_bus.req_src_zero = sz;
    core_bus.req_rd_zero  = rz;
    @(posedge clk);
    #1;
    core_bus.req_valid = 1'b0;
    n_rd = 0;
    n_wr = 0;
    lat  = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!core_bus.resp_valid && lat < 20);
    rdata = core_bus.resp_rdata;
    ill   = core_bus.resp_illegal;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, core_bus.resp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, core_bus.resp_rdata, rdata);
      check({tag, "_hold_ready"}, {31'b0, core_bus.req_ready}, 32'd0);
    end
    core_bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    core_bus.resp_ready = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_illegal"}, {31'b0, ill}, {31'b0, exp_ill});
    check({tag, "_reads"}, n_rd, exp_rd);
    check({tag, "_writes"}, n_wr, exp_wr);
    if (exp_wr != 0) check({tag, "_wdata"}, last_wdata, exp_wdata);
  endtask

  initial begin
    int seen_resp;
    core_bus.req_valid    = 1'b0;
    core_bus.req_funct3   = 3'b0;
    core_bus.req_addr     = 12'h0;
    core_bus.req_operand  = 32'h0;
    core_bus.req_src_zero = 1'b0;
    core_bus.req_rd_zero  = 1'b0;
    core_bus.resp_ready   = 1'b0;
`ifdef CSR_DBG_PORT_EN
    dbg_bus.req_valid    = 1'b0;
    dbg_bus.req_funct3   = 3'b0;
    dbg_bus.req_addr     = 12'h0;
    dbg_bus.req_operand  = 32'h0;
    dbg_bus.req_src_zero = 1'b0;
    dbg_bus.req_rd_zero  = 1'b0;
    dbg_bus.resp_ready   = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    priv = 2'b11;
    n_rd = 0; n_wr = 0; n_both = 0; last_wdata = 32'h0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready",  {31'b0, core_bus.req_ready},  32'd1);
    check("rst_resp",   {31'b0, core_bus.resp_valid}, 32'd0);
    check("rst_rd_en",  {31'b0, csr_read_en},         32'd0);
    check("rst_wr_en",  {31'b0, csr_write_en},        32'd0);
    check("rst_addr",   {20'b0, csr_addr},            32'd0);

    // CSRRW mscratch
    run_vec("rw340", 3'b001, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0, 0,
            32'h0, 1'b0, 4, 1, 1, 32'hDEADBEEF);
    check("rw340_mem", mem[12'h340], 32'hDEADBEEF);

    // CSRRS mstatus, then again with rs1=x0
    mem[12'h300] = 32'hF0000000;
    run_vec("rs300", 3'b010, 12'h300, 32'h00000008, 1'b0, 1'b0, 0,
            32'hF0000000, 1'b0, 4, 1, 1, 32'hF0000008);
    run_vec("rs300_sz", 3'b010, 12'h300, 32'h00000008, 1'b1, 1'b0, 0,
            32'hF0000008, 1'b0, 3, 1, 0, 32'h0);

    // CSRRCI clears only the zimm bits
    mem[12'h300] = 32'hFFFFFFFF;
    run_vec("rci300", 3'b111, 12'h300, 32'hFFFFFFFF, 1'b0, 1'b0, 0,
            32'hFFFFFFFF, 1'b0, 4, 1, 1, 32'hFFFFFFE0);

    // CSRRW with rd=x0 skips the read
    run_vec("rw_rdz", 3'b001, 12'h340, 32'h12340000, 1'b0, 1'b1, 0,
            32'h0, 1'b0, 3, 0, 1, 32'h12340000);

    // U-mode touching an M-mode CSR
    priv = 2'b00;
    run_vec("u_rs300", 3'b010, 12'h300, 32'h1, 1'b0, 1'b0, 0,
            32'h0, 1'b1, 2, 0, 0, 32'h0);
    priv = 2'b11;

    // writes to the read-only range, and a legal read of it
    mem[12'hC00] = 32'h12345678;
    run_vec("rw_c00", 3'b001, 12'hC00, 32'h1, 1'b0, 1'b0, 0,
            32'h0, 1'b1, 2, 0, 0, 32'h0);
    run_vec("rs_c00_sz", 3'b010, 12'hC00, 32'h0, 1'b1, 1'b0, 0,
            32'h12345678, 1'b0, 3, 1, 0, 32'h0);
    check("rw_c00_mem", mem[12'hC00], 32'h12345678);

    // reserved funct3
    run_vec("f3_100", 3'b100, 12'h340, 32'h1, 1'b0, 1'b0, 0,
            32'h0, 1'b1, 2, 0, 0, 32'h0);

    // stalled writeback
    mem[12'h340] = 32'hA5A5A5A5;
    run_vec("hold", 3'b010, 12'h340, 32'h0000000F, 1'b0, 1'b0, 3,
            32'hA5A5A5A5, 1'b0, 4, 1, 1, 32'hA5A5A5AF);

    // reset in the middle of WRITE drops the request
    @(negedge clk);
    core_bus.req_valid    = 1'b1;
    core_bus.req_funct3   = 3'b010;
    core_bus.req_addr     = 12'h340;
    core_bus.req_operand  = 32'h100;
    core_bus.req_src_zero = 1'b0;
    core_bus.req_rd_zero  = 1'b0;
    @(posedge clk);
    #1 core_bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_phase", {31'b0, csr_write_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'b0, core_bus.req_ready}, 32'd1);
    check("rst_mid_wr_en", {31'b0, csr_write_en}, 32'd0);
    seen_resp = 0;
    repeat (4) begin
      if (core_bus.resp_valid) seen_resp++;
      @(negedge clk);
    end
    check("rst_mid_noresp", seen_resp, 0);

`ifdef CSR_DBG_PORT_EN
    // simultaneous requests: debug wins the tie
    @(negedge clk);
    dbg_bus.req_valid  = 1'b1;
    core_bus.req_valid = 1'b1;
    #1;
    check("arb_dbg_ready",  {31'b0, dbg_bus.req_ready},  32'd1);
    check("arb_core_ready", {31'b0, core_bus.req_ready}, 32'd0);
    dbg_bus.req_valid  = 1'b0;
    core_bus.req_valid = 1'b0;
`endif

    check("never_both_strobes", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
